// File: rtl/seq_detector_prog.sv
// seq_detector_prog
//   Programmable serial bit-pattern detector. Accepted bits (en=1) shift into
//   a history register. A match fires when the newest len bits equal the
//   programmed pattern and at least len bits have been seen since the last
//   reset, config load or non-overlapping match. The first received bit of
//   the pattern sits at pattern bit [len-1].
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   en           x is valid this cycle
//   x            serial data bit
//   cfg_we       load cfg_pattern / cfg_len / cfg_overlap (wins over en)
//   cfg_pattern  pattern, bit [len-1] first received, bit [0] last
//   cfg_len      pattern length (0 -> 1, > MAX_LEN -> MAX_LEN)
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cnt_clr      clear match_cnt (wins over a simultaneous hit)
//   match        registered one-cycle pulse per hit
//   match_cnt    saturating count of hits
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 16,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(16'h00B5),
    parameter int                 RST_LEN     = 8,
    parameter bit                 RST_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] FULL    = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;
    logic               ovl;

    logic               accept;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic [LEN_W-1:0]   len_clamped;

    always_comb begin
        accept = en & ~cfg_we;
        hist_n = (hist << 1) | MAX_LEN'(x);
        // fill saturates so long streams never wrap back below len
        fill_n = (fill == FULL) ? fill : fill + 1'b1;

        // only the low len bits take part in the compare
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end

        hit = accept && (fill_n >= len) && (((hist_n ^ pat) & mask) == '0);

        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > FULL) begin
            len_clamped = FULL;
        end else begin
            len_clamped = cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= RST_PATTERN;
            len       <= LEN_W'(RST_LEN);
            ovl       <= RST_OVERLAP;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (cfg_we) begin
                // history is left alone; clearing fill makes it irrelevant
                pat   <= cfg_pattern;
                len   <= len_clamped;
                ovl   <= cfg_overlap;
                fill  <= '0;
                match <= 1'b0;
            end else begin
                match <= hit;
                if (accept) begin
                    hist <= hist_n;
                    // non-overlapping: restart so no bit is reused
                    fill <= (hit && !ovl) ? '0 : fill_n;
                end
            end

            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (hit && match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = 5;
    localparam int CNT_SAT = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               x = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: list of accepted bits that may still take part in a match
    bit               m_q[$];
    logic [MAX_LEN-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_cnt;
    bit               m_match;

    seq_detector_prog #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs, step the reference model across the edge,
    // and return 1 time unit after the edge, where outputs are sampled.
    task automatic cycle(input bit r, input bit e, input bit xb, input bit we, input bit clr);
        bit h;
        int cl;
        rst = r; en = e; x = xb; cfg_we = we; cnt_clr = clr;
        @(posedge clk);
        h = 1'b0;
        if (r) begin
            m_q.delete();
            m_pat = 16'h00B5; m_len = 8; m_ovl = 1'b1; m_cnt = 0;
        end else begin
            if (we) begin
                cl = int'(cfg_len);
                m_len = (cl == 0) ? 1 : ((cl > MAX_LEN) ? MAX_LEN : cl);
                m_pat = cfg_pattern;
                m_ovl = cfg_overlap;
                m_q.delete();
            end else if (e) begin
                m_q.push_back(xb);
                if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
                if (m_q.size() >= m_len) begin
                    h = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_q[m_q.size() - 1 - k] != m_pat[k]) h = 1'b0;
                end
                if (h && !m_ovl) m_q.delete();
            end
            if (clr) m_cnt = 0;
            else if (h && m_cnt < CNT_SAT) m_cnt++;
        end
        m_match = h;
        #1;
        rst = 1'b0; en = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o, input bit clr);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, clr);
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", match); end
        n_checks++;
        if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    endtask

    task automatic test_default_stream;
        logic [12:0] s;
        bit want;
        s = 13'b1011010110101;
        for (int i = 1; i <= 13; i++) begin
            cycle(1'b0, 1'b1, s[13 - i], 1'b0, 1'b0);
            want = (i == 8) || (i == 13);
            n_checks++;
            if (match !== want || match !== m_match) begin
                n_fail++; $display("FAIL dflt_match bit %0d got %b want %b", i, match, want);
            end
        end
        n_checks++;
        if (match_cnt !== 4'd2) begin n_fail++; $display("FAIL dflt_cnt got %0d want 2", match_cnt); end
    endtask

    task automatic test_nonoverlap;
        logic [12:0] s;
        bit want;
        s = 13'b1011010110101;
        load(16'h00B5, 5'd8, 1'b0, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            cycle(1'b0, 1'b1, s[13 - i], 1'b0, 1'b0);
            want = (i == 8);
            n_checks++;
            if (match !== want || match !== m_match) begin
                n_fail++; $display("FAIL novl_match bit %0d got %b want %b", i, match, want);
            end
        end
        n_checks++;
        if (match_cnt !== 4'd1) begin n_fail++; $display("FAIL novl_cnt got %0d want 1", match_cnt); end
    endtask

    task automatic test_idle_gaps;
        logic [5:0] s;
        int hits;
        s = 6'b110110;
        load(16'h0006, 5'd3, 1'b1, 1'b1);
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, s[5 - i], 1'b0, 1'b0);
            hits += match;
            n_checks++;
            if (match !== m_match) begin n_fail++; $display("FAIL idle_match bit %0d got %b want %b", i, match, m_match); end
            if (i < 2) begin
                for (int j = 0; j < 2; j++) begin
                    cycle(1'b0, 1'b0, ~s[5 - i], 1'b0, 1'b0);
                    hits += match;
                end
            end
        end
        n_checks++;
        if (hits != 1) begin n_fail++; $display("FAIL idle_hits got %0d want 1", hits); end
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, s[5 - i], 1'b0, 1'b0);
            hits += match;
        end
        n_checks++;
        if (hits != 2) begin n_fail++; $display("FAIL idle_hits2 got %0d want 2", hits); end
        n_checks++;
        if (match_cnt !== 4'd3) begin n_fail++; $display("FAIL idle_cnt got %0d want 3", match_cnt); end
    endtask

    task automatic test_cfg_priority;
        cfg_pattern = 16'h0001; cfg_len = 5'd1; cfg_overlap = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL prio_same got %b want 0", match); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL prio_next got %b want 0", match); end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b1) begin n_fail++; $display("FAIL prio_hit got %b want 1", match); end
    endtask

    task automatic test_saturate;
        load(16'h0001, 5'd1, 1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (match !== 1'b1 || match_cnt !== CNT_W'((i > CNT_SAT) ? CNT_SAT : i)) begin
                n_fail++;
                $display("FAIL sat_run i=%0d match %b cnt %0d want 1 %0d", i, match, match_cnt, (i > CNT_SAT) ? CNT_SAT : i);
            end
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (match !== 1'b1 || match_cnt !== 4'd0) begin
            n_fail++; $display("FAIL clr_hit match %b cnt %0d want 1 0", match, match_cnt);
        end
    endtask

    task automatic test_rst_midstream;
        logic [7:0] s;
        s = 8'b10110101;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, s[7 - i], 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, s[0], 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL rst_mid got %b want 0", match); end
    endtask

    task automatic test_len_clamp;
        logic [15:0] p;
        load(16'hA5A5, 5'd0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b0) begin n_fail++; $display("FAIL len0_miss got %b want 0", match); end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (match !== 1'b1) begin n_fail++; $display("FAIL len0_hit got %b want 1", match); end
        p = 16'($urandom);
        load(p, 5'd31, 1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            cycle(1'b0, 1'b1, p[i], 1'b0, 1'b0);
            n_checks++;
            if (match !== (i == 0)) begin
                n_fail++; $display("FAIL len31 bit %0d got %b want %b", 15 - i, match, (i == 0));
            end
        end
    endtask

    task automatic test_random;
        bit r, e, xb, we, clr;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            we  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 49) == 0);
            e   = ($urandom_range(0, 9) < 7);
            xb  = 1'($urandom);
            if (we) begin
                cfg_pattern = 16'($urandom);
                cfg_len     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
                cfg_overlap = 1'($urandom);
            end
            cycle(r, e, xb, we, clr);
            n_checks++;
            if (match !== m_match || match_cnt !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand cyc %0d match %b cnt %0d want %b %0d", i, match, match_cnt, m_match, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_nonoverlap();
        test_idle_gaps();
        test_cfg_priority();
        test_saturate();
        test_rst_midstream();
        test_len_clamp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
